pipe_hazard_unit: RTL
=====================

Name: pipe_hazard_unit

Overview:
- Parametrised hazard and forwarding controller for the pipelined MIPS CPU family.
- Tracks in-flight destination registers over a STAGES-deep scoreboard chain that mirrors the ID/EX ... MEM/WB pipe registers.
- Produces load-use stall/bubble, branch flush and per-operand forwarding selects.
- Sits beside the ID stage decoder; outputs drive PC write-enable, IF/ID hold/clear, ID/EX bubble mux and the EX-stage operand muxes.

Parameters:
- REG_AW, 5, register address width.
- STAGES, 3, tracked post-ID stages (entry 0=EX, 1=MEM, ..., STAGES-1=WB); legal range 2..8.
- BR_STAGE, 1, entry index where branches resolve; legal range 0..STAGES-1.
- SEL_W, $clog2(STAGES) (minimum 1), width of forwarding selects.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-low reset.
- hold_i  in  1  external freeze (e.g. memory busy); the whole chain holds.
- id_valid_i  in  1  ID holds a real instruction.
- id_rs_i  in  REG_AW  ID source register A.
- id_rt_i  in  REG_AW  ID source register B.
- id_use_rs_i  in  1  ID reads rs.
- id_use_rt_i  in  1  ID reads rt.
- id_rd_i  in  REG_AW  ID destination, after the RegDst mux.
- id_regwrite_i  in  1  ID writes the register file.
- id_memread_i  in  1  ID is a load.
- branch_taken_i  in  1  branch in entry BR_STAGE resolved taken.
- stall_o  out  1  hold PC and IF/ID.
- bubble_o  out  1  zero ID/EX control this edge.
- flush_o  out  1  clear IF/ID and all entries younger than BR_STAGE.
- fwd_a_sel_o  out  SEL_W  EX operand A source: 0=ID/EX register value, k=result of entry k.
- fwd_b_sel_o  out  SEL_W  same, for operand B.

Behaviour:
- Entry fields: valid, rd, regwrite, memread, rs, rt, use_rs, use_rt.
- Async reset (rst_i=0): all entries invalid. stall_o, bubble_o, flush_o = 0. Both fwd selects = 0. Takes effect mid-operation immediately.
- Load-use hazard, combinational: lu = id_valid_i & entry0.valid & entry0.memread & entry0.regwrite & entry0.rd!=0 & ((id_use_rs_i & id_rs_i==entry0.rd) | (id_use_rt_i & id_rt_i==entry0.rd)).
- Output equations:
  - flush_o = branch_taken_i & entry[BR_STAGE].valid.
  - stall_o = lu & ~flush_o.
  - bubble_o = (lu | flush_o | ~id_valid_i) & ~hold_i.
- Clock edge with hold_i=1: chain unchanged. stall_o is still reported; the CPU also freezes on hold_i.
- Clock edge with hold_i=0:
  - Entry k takes entry k-1 for k>=1.
  - Entry 0 takes the ID fields, or a bubble (valid=0) when bubble_o=1.
  - If flush_o is asserted, entries 1..BR_STAGE also load valid=0. The branch itself advances normally to BR_STAGE+1.
- Forwarding, combinational, from entry 0 fields: fwd_a_sel_o = smallest k in 1..STAGES-1 with entry k valid, regwrite, rd!=0 and rd==entry0.rs, gated by entry0.use_rs and entry0.valid; else 0. fwd_b_sel_o is the same using rt. Nearest producer wins.
- Register 0 never causes a hazard or a forward.
- Simultaneous lu and flush: flush wins, no stall.
- Simultaneous hold_i and flush: flush_o is reported, but the chain is not updated until hold_i drops.
- Latency: stall lasts exactly one cycle per load-use. Forward selects are valid in the same cycle the consumer occupies entry 0.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, add outputs stall_cnt_o[31:0] and flush_cnt_o[31:0].
  - Each increments on every non-held edge where stall_o or flush_o (respectively) is 1.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- When undefined, these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Reset: rst_i=0 with random inputs -> stall_o=0, flush_o=0, fwd selects=0. After release with id_valid_i=0 for 4 cycles -> all entries invalid, bubble_o=1.
- Load-use: lw $8 then add $9,$8,$2 in ID -> stall_o=1 for exactly one cycle. Next cycle the add is in EX with fwd_a_sel_o=2 (WB), since STAGES=3 and the load is then in entry 2.
- EX/MEM forward: add $3,$1,$1 then sub $4,$3,$3 -> when sub is in EX, fwd_a_sel_o=1 and fwd_b_sel_o=1. Nearest-producer check: with add $3 in entry 2 and or $3 in entry 1 -> fwd_a_sel_o=1.
- Branch flush: beq taken in entry 1 -> flush_o=1 for one cycle; entry 0 and the incoming ID become invalid. A concurrent load-use in the same cycle gives stall_o=0.
- Register 0 / hold: lw $0 followed by a consumer of $0 -> no stall, fwd selects 0. hold_i=1 for 3 cycles -> chain contents and fwd selects frozen.
- HAZARD_PERF_CNT_EN defined: 5 load-use stalls and 2 flushes -> stall_cnt_o=5, flush_cnt_o=2. Counters preloaded near max stick at 32'hFFFFFFFF.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_unit
// Description : Hazard and forwarding controller for the pipelined MIPS CPU.
//               A STAGES-deep scoreboard mirrors the ID/EX .. MEM/WB pipe
//               registers. From it the unit derives the load-use stall and
//               bubble, the branch flush and the EX operand forwarding selects.
//               Optional macro HAZARD_PERF_CNT_EN adds saturating stall and
//               flush event counters (stall_cnt_o, flush_cnt_o).
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_unit #(
  parameter int REG_AW   = 5,
  parameter int STAGES   = 3,
  parameter int BR_STAGE = 1,
  parameter int SEL_W    = (STAGES <= 2) ? 1 : $clog2(STAGES)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hold_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              branch_taken_i,
  output logic              stall_o,
  output logic              bubble_o,
  output logic              flush_o,
  output logic [SEL_W-1:0]  fwd_a_sel_o,
  output logic [SEL_W-1:0]  fwd_b_sel_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);

  // One scoreboard entry per tracked post-ID pipe register.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              use_rs;
    logic              use_rt;
  } entry_t;

  entry_t ent [STAGES];
  entry_t id_entry;

  logic rs_hit;
  logic rt_hit;
  logic load_use;
  logic [STAGES-1:0] producer;

  // A load in EX whose destination is read by the instruction in ID.
  assign rs_hit   = id_use_rs_i && (id_rs_i == ent[0].rd);
  assign rt_hit   = id_use_rt_i && (id_rt_i == ent[0].rd);
  assign load_use = id_valid_i && ent[0].valid && ent[0].memread &&
                    ent[0].regwrite && (ent[0].rd != '0) && (rs_hit || rt_hit);

  // A taken branch squashes younger work, so it overrides the load-use stall.
  // bubble_o is forced low while reset is asserted.
  assign flush_o  = branch_taken_i && ent[BR_STAGE].valid;
  assign stall_o  = load_use && !flush_o;
  assign bubble_o = (load_use || flush_o || !id_valid_i) && !hold_i && rst_i;

  // Fields of the instruction leaving ID; a bubble enters as an invalid entry.
  always_comb begin
    id_entry          = '0;
    id_entry.valid    = !bubble_o;
    id_entry.rd       = id_rd_i;
    id_entry.regwrite = id_regwrite_i;
    id_entry.memread  = id_memread_i;
    id_entry.rs       = id_rs_i;
    id_entry.rt       = id_rt_i;
    id_entry.use_rs   = id_use_rs_i;
    id_entry.use_rt   = id_use_rt_i;
  end

  // Scoreboard shift chain; frozen on hold, younger-than-branch entries cleared on flush.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 0; k < STAGES; k++) begin
        ent[k] <= '0;
      end
    end else if (!hold_i) begin
      ent[0] <= id_entry;
      for (int k = 1; k < STAGES; k++) begin
        ent[k] <= ent[k-1];
        if (flush_o && (k <= BR_STAGE)) begin
          ent[k].valid <= 1'b0;
        end
      end
    end
  end

  // Entries holding a live, non-zero register result that can be forwarded.
  always_comb begin
    producer = '0;
    for (int k = 1; k < STAGES; k++) begin
      producer[k] = ent[k].valid && ent[k].regwrite && (ent[k].rd != '0);
    end
  end

  // Nearest producer wins: scan oldest to youngest so the smallest k lands last.
  always_comb begin
    fwd_a_sel_o = '0;
    fwd_b_sel_o = '0;
    for (int k = STAGES - 1; k >= 1; k--) begin
      if (producer[k] && (ent[k].rd == ent[0].rs)) begin
        fwd_a_sel_o = SEL_W'(k);
      end
      if (producer[k] && (ent[k].rd == ent[0].rt)) begin
        fwd_b_sel_o = SEL_W'(k);
      end
    end
    if (!(ent[0].valid && ent[0].use_rs)) begin
      fwd_a_sel_o = '0;
    end
    if (!(ent[0].valid && ent[0].use_rt)) begin
      fwd_b_sel_o = '0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating event counters, advanced only on edges where the chain moves.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else if (!hold_i) begin
      if (stall_o && (stall_cnt_o != 32'hFFFF_FFFF)) begin
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
      if (flush_o && (flush_cnt_o != 32'hFFFF_FFFF)) begin
        flush_cnt_o <= flush_cnt_o + 32'd1;
      end
    end
  end
`else
  // Event counters are not built in this configuration.
`endif

endmodule
`default_nettype wire
